// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and widths for the IF / EX-MEM unified memory port arbiter.
package sram_port_arbiter_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DREQ  = 3'd1,
    S_DWAIT = 3'd2,
    S_IREQ  = 3'd3,
    S_IWAIT = 3'd4
  } arb_state_e;

  // Packed request = {wr, wstrb, addr, wdata}
  function automatic int mem_req_wd(input int addr_w, input int data_w);
    return 1 + data_w / 8 + addr_w + data_w;
  endfunction

  localparam int MEM_REQ_WD = mem_req_wd(DEF_ADDR_W, DEF_DATA_W);

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Shared memory port bundle: the arbiter is the master, the SRAM controller the slave.
interface sram_port_arbiter_if
  import sram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic                  mem_req;
  logic                  mem_wr;
  logic [DATA_W/8-1:0]   mem_wstrb;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_addr_ok;
  logic                  mem_data_ok;
  logic [DATA_W-1:0]     mem_rdata;

  modport master (
    output mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata
  );

  modport slave (
    input  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata
  );

endinterface

// File: rtl/sram_port_arbiter.sv
// Serialises instruction fetch and data accesses onto one memory port, data first,
// one transaction outstanding, and holds the core in stall until both sides are served.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_en,
  input  logic [ADDR_W-1:0]     inst_addr,
  output logic [DATA_W-1:0]     inst_rdata,
  input  logic                  data_en,
  input  logic [DATA_W/8-1:0]   data_wen,
  input  logic [ADDR_W-1:0]     data_addr,
  input  logic [DATA_W-1:0]     data_wdata,
  output logic [DATA_W-1:0]     data_rdata,
  input  logic                  pipe_advance,
  output logic                  stallreq_for_mem,
  sram_port_arbiter_if.master   mem
);

  localparam int STRB_W = DATA_W / 8;
  localparam int REQ_W  = mem_req_wd(ADDR_W, DATA_W);

  arb_state_e        state_q, state_d;
  logic              ready_q, ready_d;
  logic              mem_req_q, mem_req_d;
  logic [REQ_W-1:0]  req_q, req_d;
  logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
  logic              inst_served_q, inst_served_d;
  logic              data_served_q, data_served_d;

  logic              data_pending;
  logic              inst_pending;
  logic              data_done;
  logic              inst_done;
  logic [REQ_W-1:0]  data_req_fields;
  logic [REQ_W-1:0]  inst_req_fields;

  assign data_pending     = data_en & ~data_served_q;
  assign inst_pending     = inst_en & ~inst_served_q;
  assign stallreq_for_mem = data_pending | inst_pending;

  assign data_req_fields = {|data_wen, data_wen, data_addr, data_wdata};
  assign inst_req_fields = {1'b0, {STRB_W{1'b0}}, inst_addr, {DATA_W{1'b0}}};

  assign mem.mem_req = mem_req_q;
  assign {mem.mem_wr, mem.mem_wstrb, mem.mem_addr, mem.mem_wdata} = req_q;
  assign inst_rdata  = inst_rdata_q;
  assign data_rdata  = data_rdata_q;

  // A response completes only when accepted in x_REQ or waited for in x_WAIT.
  assign data_done = ((state_q == S_DREQ) & mem.mem_addr_ok & mem.mem_data_ok)
                   | ((state_q == S_DWAIT) & mem.mem_data_ok);
  assign inst_done = ((state_q == S_IREQ) & mem.mem_addr_ok & mem.mem_data_ok)
                   | ((state_q == S_IWAIT) & mem.mem_data_ok);

  always_comb begin
    state_d       = state_q;
    ready_d       = 1'b1;
    mem_req_d     = mem_req_q;
    req_d         = req_q;
    inst_rdata_d  = inst_rdata_q;
    data_rdata_d  = data_rdata_q;
    inst_served_d = inst_served_q;
    data_served_d = data_served_q;

    if (pipe_advance) begin
      inst_served_d = 1'b0;
      data_served_d = 1'b0;
    end

    // ready_q holds off the first decision so no request leaves on the first edge after reset.
    case (state_q)
      S_IDLE: begin
        if (ready_q && data_pending) begin
          state_d   = S_DREQ;
          mem_req_d = 1'b1;
          req_d     = data_req_fields;
        end else if (ready_q && inst_pending) begin
          state_d   = S_IREQ;
          mem_req_d = 1'b1;
          req_d     = inst_req_fields;
        end
      end
      S_DREQ: begin
        if (mem.mem_addr_ok) begin
          mem_req_d = 1'b0;
          state_d   = mem.mem_data_ok ? S_IDLE : S_DWAIT;
        end
      end
      S_DWAIT: begin
        if (mem.mem_data_ok) state_d = S_IDLE;
      end
      S_IREQ: begin
        if (mem.mem_addr_ok) begin
          mem_req_d = 1'b0;
          state_d   = mem.mem_data_ok ? S_IDLE : S_IWAIT;
        end
      end
      S_IWAIT: begin
        if (mem.mem_data_ok) state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    // Completion is applied after the window clear so a coincident set wins.
    if (data_done) begin
      if (!req_q[REQ_W-1]) data_rdata_d = mem.mem_rdata;
      data_served_d = 1'b1;
    end
    if (inst_done) begin
      inst_rdata_d  = mem.mem_rdata;
      inst_served_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      ready_q       <= 1'b0;
      mem_req_q     <= 1'b0;
      req_q         <= '0;
      inst_rdata_q  <= '0;
      data_rdata_q  <= '0;
      inst_served_q <= 1'b0;
      data_served_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ready_q       <= ready_d;
      mem_req_q     <= mem_req_d;
      req_q         <= req_d;
      inst_rdata_q  <= inst_rdata_d;
      data_rdata_q  <= data_rdata_d;
      inst_served_q <= inst_served_d;
      data_served_q <= data_served_d;
    end
  end

endmodule
